wb_reg_bank: RTL and testbench

WB_REG_BANK -- requirements
Module: wb_reg_bank

---
 rtl/wb_reg_bank.sv | 167 ++++++++++++++++
 tb/tb_wb_reg_bank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_reg_bank.sv
// wb_reg_bank
//   Wishbone classic slave holding NREGS 32-bit registers at BASE_ADDR.
//   Every access ends with ACK or ERR one cycle after it is accepted, so
//   back-to-back accesses complete every two cycles. PULSE_MASK registers
//   keep a written value only for the response cycle. RO_MASK registers
//   return status_i on reads and reject writes with ERR.
//
// Ports
//   p_clk, p_resetn            clock (rising edge), async active-low reset
//   p_wb_ADR_I/DAT_I/SEL_I     byte address, write data, byte enables
//   p_wb_CYC_I/STB_I/WE_I      classic cycle controls (LOCK_I ignored)
//   p_wb_DAT_O                 read data, nonzero only with ACK
//   p_wb_ACK_O/ERR_O/RTY_O     termination (RTY always 0)
//   regs_o                     flat register contents, reg k at [32k+31:32k]
//   wr_pulse_o                 per-register write strobe, high in RESP
//   status_i                   read values for RO_MASK registers
//
// FSM states
//   state  | meaning
//   S_IDLE | waiting for CYC & STB; decode, write and read capture on exit
//   S_RESP | ACK or ERR driven for one cycle; request ignored here

module wb_reg_bank #(
  parameter logic [31:0]      BASE_ADDR  = 32'hB000_0000,
  parameter int               NREGS      = 9,
  parameter logic [NREGS-1:0] PULSE_MASK = 9'b010101010,
  parameter logic [NREGS-1:0] RO_MASK    = '0
) (
  input  logic                  p_clk,
  input  logic                  p_resetn,
  input  logic [31:0]           p_wb_DAT_I,
  output logic [31:0]           p_wb_DAT_O,
  input  logic [31:0]           p_wb_ADR_I,
  input  logic [3:0]            p_wb_SEL_I,
  input  logic                  p_wb_CYC_I,
  input  logic                  p_wb_STB_I,
  input  logic                  p_wb_WE_I,
  input  logic                  p_wb_LOCK_I,
  output logic                  p_wb_ACK_O,
  output logic                  p_wb_ERR_O,
  output logic                  p_wb_RTY_O,
  output logic [32*NREGS-1:0]   regs_o,
  output logic [NREGS-1:0]      wr_pulse_o,
  input  logic [32*NREGS-1:0]   status_i
);

  localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;
  // Range compare is done on 33 bits so a bank ending at 2^32 cannot wrap.
  localparam logic [32:0] LP_END = {1'b0, BASE_ADDR} + 33'(4 * NREGS);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_req;
  logic              w_hit;
  logic              w_aligned;
  logic              w_is_ro;
  logic              w_ok;
  logic              w_wr_en;
  logic [31:0]       w_off;
  logic [IDXW-1:0]   w_idx;
  logic [31:0]       w_rdata;
  logic [NREGS-1:0]  w_pulse_nxt;
  logic              w_unused;

  logic [31:0]       r_regs [NREGS];
  logic [NREGS-1:0]  r_wr_pulse;
  logic [31:0]       r_dat;
  logic              r_ack;
  logic              r_err;

  assign w_req     = p_wb_CYC_I & p_wb_STB_I;
  assign w_hit     = (p_wb_ADR_I >= BASE_ADDR) && ({1'b0, p_wb_ADR_I} < LP_END);
  assign w_aligned = (p_wb_ADR_I[1:0] == 2'b00);
  assign w_off     = p_wb_ADR_I - BASE_ADDR;
  assign w_idx     = w_off[IDXW+1:2];
  assign w_ok      = w_hit & w_aligned & ~(p_wb_WE_I & w_is_ro);
  assign w_wr_en   = w_accept & p_wb_WE_I & w_ok;

  assign w_unused  = ^{p_wb_LOCK_I, status_i, w_off};

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = S_RESP;
          w_accept    = 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Index decode by comparison keeps every select in range even on a miss.
  always_comb begin
    w_is_ro     = 1'b0;
    w_rdata     = '0;
    w_pulse_nxt = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (w_idx == IDXW'(k)) begin
        w_is_ro        = RO_MASK[k];
        w_rdata        = RO_MASK[k] ? status_i[32*k +: 32] : r_regs[k];
        w_pulse_nxt[k] = w_wr_en & (p_wb_SEL_I != 4'b0000);
      end
    end
  end

  // Self-clearing registers are zeroed on every edge they are not written,
  // so a written value survives exactly the RESP cycle.
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        if (w_wr_en && (w_idx == IDXW'(k))) begin
          for (int n = 0; n < 4; n++) begin
            if (p_wb_SEL_I[n]) begin
              r_regs[k][8*n +: 8] <= p_wb_DAT_I[8*n +: 8];
            end
          end
        end else if (PULSE_MASK[k]) begin
          r_regs[k] <= '0;
        end
      end
    end
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dat      <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_ack      <= w_accept & w_ok;
      r_err      <= w_accept & ~w_ok;
      r_dat      <= (w_accept && w_ok && !p_wb_WE_I) ? w_rdata : 32'h0;
      r_wr_pulse <= w_pulse_nxt;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
    assign regs_o[32*g +: 32] = r_regs[g];
  end

  assign p_wb_DAT_O = r_dat;
  assign p_wb_ACK_O = r_ack;
  assign p_wb_ERR_O = r_err;
  assign p_wb_RTY_O = 1'b0;
  assign wr_pulse_o = r_wr_pulse;

endmodule

// File: tb/tb_wb_reg_bank.sv
// Directed bench for wb_reg_bank (9 registers, register 8 read-only).

module tb_wb_reg_bank;

  logic          p_clk = 1'b0;
  logic          p_resetn;
  logic [31:0]   dat_i, dat_o, adr_i;
  logic [3:0]    sel_i;
  logic          cyc_i, stb_i, we_i, lock_i;
  logic          ack_o, err_o, rty_o;
  logic [287:0]  regs_o;
  logic [8:0]    wr_pulse_o;
  logic [287:0]  status_i;

  always #5 p_clk = ~p_clk;

  wb_reg_bank #(
    .RO_MASK(9'b100000000)
  ) dut (
    .p_clk       (p_clk),
    .p_resetn    (p_resetn),
    .p_wb_DAT_I  (dat_i),
    .p_wb_DAT_O  (dat_o),
    .p_wb_ADR_I  (adr_i),
    .p_wb_SEL_I  (sel_i),
    .p_wb_CYC_I  (cyc_i),
    .p_wb_STB_I  (stb_i),
    .p_wb_WE_I   (we_i),
    .p_wb_LOCK_I (lock_i),
    .p_wb_ACK_O  (ack_o),
    .p_wb_ERR_O  (err_o),
    .p_wb_RTY_O  (rty_o),
    .regs_o      (regs_o),
    .wr_pulse_o  (wr_pulse_o),
    .status_i    (status_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]  e_regs [9];
  logic         s_ack, s_err, s_ack2, s_err2;
  logic [31:0]  s_dat, s_dat2;
  logic [8:0]   s_pulse, s_pulse2;
  logic [287:0] s_regs, s_regs2;

  function automatic logic [287:0] exp_regs();
    logic [287:0] v;
    for (int k = 0; k < 9; k++) v[32*k +: 32] = e_regs[k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access: response sampled 1ns after the accepting edge (RESP),
  // then the request is dropped and the following IDLE cycle sampled too.
  task automatic access(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel);
    @(negedge p_clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
    @(posedge p_clk); #1;
    s_ack = ack_o; s_err = err_o; s_dat = dat_o; s_pulse = wr_pulse_o; s_regs = regs_o;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge p_clk); #1;
    s_ack2 = ack_o; s_err2 = err_o; s_dat2 = dat_o; s_pulse2 = wr_pulse_o; s_regs2 = regs_o;
  endtask

  initial begin
    p_resetn = 1'b0;
    dat_i = '0; adr_i = '0; sel_i = '0;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; lock_i = 1'b0;
    for (int k = 0; k < 8; k++) status_i[32*k +: 32] = 32'h5A5A_0000 + 32'(k);
    status_i[32*8 +: 32] = 32'hCAFE_F00D;
    for (int k = 0; k < 9; k++) e_regs[k] = '0;

    repeat (3) @(posedge p_clk);
    #1;
    chk("reset_ack",   ack_o, 1'b0);
    chk("reset_err",   err_o, 1'b0);
    chk("reset_rty",   rty_o, 1'b0);
    chk("reset_dat",   dat_o, 32'h0);
    chk("reset_regs",  regs_o, exp_regs());
    chk("reset_pulse", wr_pulse_o, 9'h0);
    @(negedge p_clk);
    p_resetn = 1'b1;

    // Plain register write and read back
    access(1'b1, 32'hB000_0008, 32'hDEAD_BEEF, 4'hF);
    e_regs[2] = 32'hDEAD_BEEF;
    chk("wr2_ack",     s_ack, 1'b1);
    chk("wr2_err",     s_err, 1'b0);
    chk("wr2_regs",    s_regs, exp_regs());
    chk("wr2_pulse",   s_pulse, 9'b000000100);
    chk("wr2_pulse_off", s_pulse2, 9'h0);
    chk("wr2_ack_off", s_ack2, 1'b0);
    access(1'b0, 32'hB000_0008, 32'h0, 4'hF);
    chk("rd2_ack",     s_ack, 1'b1);
    chk("rd2_dat",     s_dat, 32'hDEAD_BEEF);
    chk("rd2_pulse",   s_pulse, 9'h0);
    chk("rd2_dat_idle", s_dat2, 32'h0);

    // Self-clearing register 1
    access(1'b1, 32'hB000_0004, 32'h0000_0005, 4'hF);
    e_regs[1] = 32'h5;
    chk("pulse1_ack",   s_ack, 1'b1);
    chk("pulse1_regs",  s_regs, exp_regs());
    chk("pulse1_strb",  s_pulse, 9'b000000010);
    e_regs[1] = 32'h0;
    chk("pulse1_clear", s_regs2, exp_regs());
    chk("pulse1_strb_off", s_pulse2, 9'h0);

    // Byte enables
    access(1'b1, 32'hB000_0000, 32'hFFFF_FFFF, 4'hF);
    access(1'b1, 32'hB000_0000, 32'h1234_5678, 4'b0101);
    e_regs[0] = 32'hFF34_FF78;
    chk("sel_ack",  s_ack, 1'b1);
    chk("sel_regs", s_regs, exp_regs());
    access(1'b0, 32'hB000_0000, 32'h0, 4'hF);
    chk("sel_rd",   s_dat, 32'hFF34_FF78);

    // SEL=0 write: ACK, no change, no pulse
    access(1'b1, 32'hB000_0008, 32'h0000_0000, 4'h0);
    chk("sel0_ack",   s_ack, 1'b1);
    chk("sel0_regs",  s_regs, exp_regs());
    chk("sel0_pulse", s_pulse, 9'h0);

    // Misses and misalignment
    access(1'b1, 32'hB000_0024, 32'h1111_1111, 4'hF);
    chk("miss_hi_err",   s_err, 1'b1);
    chk("miss_hi_ack",   s_ack, 1'b0);
    chk("miss_hi_regs",  s_regs, exp_regs());
    chk("miss_hi_pulse", s_pulse, 9'h0);
    access(1'b0, 32'hB000_0024, 32'h0, 4'hF);
    chk("miss_hi_rd_err", s_err, 1'b1);
    chk("miss_hi_rd_dat", s_dat, 32'h0);
    access(1'b0, 32'hB000_0002, 32'h0, 4'hF);
    chk("misalign_err", s_err, 1'b1);
    chk("misalign_ack", s_ack, 1'b0);
    chk("misalign_dat", s_dat, 32'h0);
    access(1'b1, 32'hAFFF_FFFC, 32'h2222_2222, 4'hF);
    chk("miss_lo_err",   s_err, 1'b1);
    chk("miss_lo_regs",  s_regs, exp_regs());
    chk("miss_lo_pulse", s_pulse, 9'h0);
    chk("err_off",       s_err2, 1'b0);

    // Read-only register 8 (last address of the bank)
    access(1'b0, 32'hB000_0020, 32'h0, 4'hF);
    chk("ro_rd_ack", s_ack, 1'b1);
    chk("ro_rd_dat", s_dat, 32'hCAFE_F00D);
    access(1'b1, 32'hB000_0020, 32'h3333_3333, 4'hF);
    chk("ro_wr_err",   s_err, 1'b1);
    chk("ro_wr_ack",   s_ack, 1'b0);
    chk("ro_wr_regs",  s_regs, exp_regs());
    chk("ro_wr_pulse", s_pulse, 9'h0);

    // Self-clearing register read back after clearing
    access(1'b0, 32'hB000_001C, 32'h0, 4'hF);
    chk("rd7_ack", s_ack, 1'b1);
    chk("rd7_dat", s_dat, 32'h0);

    // Held request completes every second cycle
    @(negedge p_clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'hB000_0008;
    for (int i = 0; i < 4; i++) begin
      @(posedge p_clk); #1;
      chk("b2b_ack", ack_o, (i % 2 == 0));
      chk("b2b_dat", dat_o, (i % 2 == 0) ? 32'hDEAD_BEEF : 32'h0);
    end
    cyc_i = 1'b0; stb_i = 1'b0;

    // Reset during the response of a write to register 4
    @(negedge p_clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'hB000_0010;
    dat_i = 32'h0000_0044; sel_i = 4'hF;
    @(posedge p_clk); #2;
    p_resetn = 1'b0;
    #1;
    for (int k = 0; k < 9; k++) e_regs[k] = '0;
    chk("rst_mid_ack",   ack_o, 1'b0);
    chk("rst_mid_dat",   dat_o, 32'h0);
    chk("rst_mid_regs",  regs_o, exp_regs());
    chk("rst_mid_pulse", wr_pulse_o, 9'h0);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge p_clk); #1;
    chk("rst_hold_ack", ack_o, 1'b0);
    @(negedge p_clk);
    p_resetn = 1'b1;
    @(posedge p_clk); #1;
    chk("rst_rel_ack", ack_o, 1'b0);
    access(1'b1, 32'hB000_0010, 32'h0000_0044, 4'hF);
    e_regs[4] = 32'h44;
    chk("post_rst_ack",   s_ack, 1'b1);
    chk("post_rst_regs",  s_regs, exp_regs());
    chk("post_rst_pulse", s_pulse, 9'b000010000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
